// File: rtl/video_stream_rx.sv
// video_stream_rx
//   Receives a DE/HS/VS pixel stream and re-times it by one clock. It tags
//   each pixel with its column/row and measures the active size of every
//   complete frame.
//
// Ports
//   clk, rst                  pixel clock and synchronous active-high reset
//   de_in, hs_in, vs_in       data enable, horizontal and vertical sync (active-high)
//   r_in, g_in, b_in          8-bit pixel components
//   de_out, hs_out, vs_out    registered syncs; de_out is held low until the
//                             first vsync after reset
//   r_out, g_out, b_out       registered pixel components
//   x_out, y_out              column/row of the pixel on the outputs
//                             (these hold their last value while de_out=0)
//   line_start, frame_start   one-cycle pulses aligned with the first pixel
//                             of a line, and with pixel (0,0)
//   width_meas, height_meas   active size of the last complete frame
//   meas_valid                one-cycle pulse when the measurements update
//   frame_cnt                 count of completed frames, wraps at 256
//   err_width, err_ovf        sticky line-length and counter-saturation
//                             flags, cleared at each frame close
//   state_dbg                 current FSM state, for debug visibility
module video_stream_rx (
   input  logic        clk,
   input  logic        rst,
   input  logic        de_in,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic [7:0]  r_in,
   input  logic [7:0]  g_in,
   input  logic [7:0]  b_in,
   output logic        de_out,
   output logic        hs_out,
   output logic        vs_out,
   output logic [7:0]  r_out,
   output logic [7:0]  g_out,
   output logic [7:0]  b_out,
   output logic [10:0] x_out,
   output logic [10:0] y_out,
   output logic        line_start,
   output logic        frame_start,
   output logic [10:0] width_meas,
   output logic [10:0] height_meas,
   output logic        meas_valid,
   output logic [7:0]  frame_cnt,
   output logic        err_width,
   output logic        err_ovf,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      WAIT_VS   = 2'd0,
      WAIT_LINE = 2'd1,
      ACTIVE    = 2'd2,
      BLANK     = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic        de_q, vs_q;
   logic        frame_edge, line_rise, line_fall;
   logic        close_frame, start_first, start_next;
   logic        pix_cont, line_done, ovf_set;
   logic        x_sat, y_sat;
   logic [10:0] x_nx, y_nx, height_nx, width_nx;
   logic [11:0] line_len, ref_width;
   logic        first_line;

   assign state_dbg = state;

   always_comb begin
      frame_edge  = vs_in & ~vs_q;
      line_rise   = de_in & ~de_q;
      line_fall   = ~de_in & de_q;
      close_frame = frame_edge & ((state == ACTIVE) || (state == BLANK));
      state_nx    = state;
      start_first = 1'b0;
      start_next  = 1'b0;
      // A frame edge wins over everything; a DE rise in the same cycle
      // opens row 0 of the new frame right away.
      if (frame_edge) begin
         if (line_rise) begin
            state_nx    = ACTIVE;
            start_first = 1'b1;
         end else begin
            state_nx = WAIT_LINE;
         end
      end else begin
         case (state)
            WAIT_LINE: if (line_rise) begin
               state_nx    = ACTIVE;
               start_first = 1'b1;
            end
            ACTIVE:    if (line_fall) state_nx = BLANK;
            BLANK:     if (line_rise) begin
               state_nx   = ACTIVE;
               start_next = 1'b1;
            end
            default:   state_nx = WAIT_VS;
         endcase
      end

      // Only pixels of a line opened inside the current frame advance x.
      // A vsync arriving mid-line leaves x frozen for the rest of that line.
      pix_cont  = (state == ACTIVE) & de_in & ~frame_edge;
      line_done = (state == ACTIVE) & line_fall & ~frame_edge;
      x_sat     = (x_out == 11'h7FF);
      y_sat     = (y_out == 11'h7FF);
      ovf_set   = (pix_cont & x_sat) | (start_next & y_sat);

      x_nx = x_out;
      if (start_first || start_next) x_nx = 11'd0;
      else if (pix_cont && !x_sat)   x_nx = x_out + 11'd1;

      y_nx = y_out;
      if (start_first)              y_nx = 11'd0;
      else if (start_next && !y_sat) y_nx = y_out + 11'd1;

      line_len  = {1'b0, x_out} + 12'd1;
      // A saturated line reports 2048, which cannot fit in 11 bits.
      width_nx  = ref_width[11] ? 11'h7FF : ref_width[10:0];
      height_nx = y_sat ? 11'h7FF : y_out + 11'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WAIT_VS;
         de_q        <= 1'b0;
         vs_q        <= 1'b0;
         de_out      <= 1'b0;
         hs_out      <= 1'b0;
         vs_out      <= 1'b0;
         r_out       <= 8'd0;
         g_out       <= 8'd0;
         b_out       <= 8'd0;
         x_out       <= 11'd0;
         y_out       <= 11'd0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         width_meas  <= 11'd0;
         height_meas <= 11'd0;
         meas_valid  <= 1'b0;
         frame_cnt   <= 8'd0;
         err_width   <= 1'b0;
         err_ovf     <= 1'b0;
         first_line  <= 1'b0;
         ref_width   <= 12'd0;
      end else begin
         state       <= state_nx;
         de_q        <= de_in;
         vs_q        <= vs_in;
         de_out      <= de_in & (state_nx != WAIT_VS);
         hs_out      <= hs_in;
         vs_out      <= vs_in;
         r_out       <= r_in;
         g_out       <= g_in;
         b_out       <= b_in;
         x_out       <= x_nx;
         y_out       <= y_nx;
         line_start  <= start_first | start_next;
         frame_start <= start_first;
         meas_valid  <= close_frame;
         if (close_frame) begin
            width_meas  <= width_nx;
            height_meas <= height_nx;
            frame_cnt   <= frame_cnt + 8'd1;
            err_width   <= 1'b0;
            err_ovf     <= 1'b0;
         end else begin
            if (line_done && !first_line && (line_len != ref_width)) err_width <= 1'b1;
            if (ovf_set) err_ovf <= 1'b1;
         end
         // The first complete line of a frame becomes the width reference.
         if (start_first) begin
            first_line <= 1'b1;
            ref_width  <= 12'd0;
         end else if (line_done) begin
            first_line <= 1'b0;
            if (first_line) ref_width <= line_len;
         end
      end
   end

endmodule

// File: tb/tb_video_stream_rx.sv
// tb_video_stream_rx
//   Directed bench for video_stream_rx: a vector table for the reset state
//   and a small hand-built frame, then full-size and tiny frame sequences
//   for the multi-cycle cases (measurement, short line, reset mid-frame,
//   simultaneous edges, saturation and frame counter wrap).
module tb_video_stream_rx;

   localparam int HS = 2, HBP = 8, HFP = 8, VSW = 4, VBP = 8, VFP = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        de_in, hs_in, vs_in;
   logic [7:0]  r_in, g_in, b_in;
   logic        de_out, hs_out, vs_out;
   logic [7:0]  r_out, g_out, b_out;
   logic [10:0] x_out, y_out;
   logic        line_start, frame_start;
   logic [10:0] width_meas, height_meas;
   logic        meas_valid;
   logic [7:0]  frame_cnt;
   logic        err_width, err_ovf;
   logic [1:0]  state_dbg;

   video_stream_rx dut (
      .clk(clk), .rst(rst),
      .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .x_out(x_out), .y_out(y_out),
      .line_start(line_start), .frame_start(frame_start),
      .width_meas(width_meas), .height_meas(height_meas),
      .meas_valid(meas_valid), .frame_cnt(frame_cnt),
      .err_width(err_width), .err_ovf(err_ovf),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Values captured at the most recent meas_valid pulse.
   int          mv_seen;
   logic [10:0] mv_w, mv_h;
   logic [7:0]  mv_fc;
   logic        mv_ew, mv_eo;
   bit          err_w_seen, err_o_seen, de_seen;

   typedef struct {
      logic        rst, vs, hs, de;
      logic [23:0] rgb;
      logic        de_o, hs_o, vs_o;
      logic [23:0] rgb_o;
      logic [10:0] x, y;
      logic        ls, fs, mv;
      logic [10:0] wm, hm;
      logic [7:0]  fc;
      logic        ew, eo;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (meas_valid) begin
         mv_seen++;
         mv_w  = width_meas;
         mv_h  = height_meas;
         mv_fc = frame_cnt;
         mv_ew = err_width;
         mv_eo = err_ovf;
      end
      if (frame_start)
         check("frame_start_at_origin", 64'({de_out, x_out, y_out}), 64'({1'b1, 11'd0, 11'd0}));
      if (err_width) err_w_seen = 1'b1;
      if (err_ovf)   err_o_seen = 1'b1;
      if (de_out)    de_seen    = 1'b1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1; de_in = 1'b0; vs_in = 1'b0; hs_in = 1'b0;
      tick();
      rst = 1'b0;
      mv_seen = 0;
   endtask

   // Full frame with the standard blanking; optional short line, reset
   // pulse at pixel (30, rst_y) and probe of pixel (5,3).
   task automatic gen_frame(input int w, input int h, input int short_y, input int short_len,
                            input int rst_y, input bit probe);
      for (int l = 0; l < VSW + VBP + h + VFP; l++) begin
         int yy;
         int len;
         yy = l - (VSW + VBP);
         vs_in = (l < VSW);
         hs_in = 1'b1;
         de_in = 1'b0;
         repeat (HS) tick();
         hs_in = 1'b0;
         repeat (HBP) tick();
         if (yy >= 0 && yy < h) begin
            len = (yy == short_y) ? short_len : w;
            for (int xx = 0; xx < len; xx++) begin
               de_in = 1'b1;
               if (xx == 5 && yy == 3) {r_in, g_in, b_in} = 24'h112233;
               else {r_in, g_in, b_in} = {xx[7:0], yy[7:0], 8'h5a};
               if (yy == rst_y && xx == 30) rst = 1'b1;
               tick();
               if (rst) begin
                  rst = 1'b0;
                  mv_seen = 0;
                  de_seen = 1'b0;
                  check("reset_outputs_a", 64'({de_out, hs_out, vs_out, r_out, g_out, b_out, x_out, y_out}), 64'd0);
                  check("reset_outputs_b", 64'({line_start, frame_start, width_meas, height_meas,
                                                 meas_valid, frame_cnt, err_width, err_ovf, state_dbg}), 64'd0);
               end else if (probe && xx == 5 && yy == 3) begin
                  check("pixel_5_3", 64'({de_out, x_out, y_out, r_out, g_out, b_out}),
                        64'({1'b1, 11'd5, 11'd3, 24'h112233}));
               end
            end
            de_in = 1'b0;
         end
         repeat (HFP) tick();
      end
   endtask

   // Minimal frame: w x h with one idle cycle after each line. With
   // coincide=1 the vsync rise lands on the first DE cycle of line 0.
   task automatic tiny_frame(input int w, input int h, input bit coincide);
      if (!coincide) begin
         vs_in = 1'b1; de_in = 1'b0; tick();
         vs_in = 1'b0; tick();
      end
      for (int yy = 0; yy < h; yy++) begin
         for (int xx = 0; xx < w; xx++) begin
            de_in = 1'b1;
            vs_in = coincide && yy == 0 && xx == 0;
            tick();
            if (coincide && yy == 0 && xx == 0)
               check("coincide_pulses", 64'({meas_valid, frame_start, de_out, x_out, y_out}),
                     64'({1'b1, 1'b1, 1'b1, 11'd0, 11'd0}));
         end
         de_in = 1'b0; vs_in = 1'b0;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
      r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;
      mv_seen = 0; mv_w = '0; mv_h = '0; mv_fc = '0; mv_ew = 1'b0; mv_eo = 1'b0;
      err_w_seen = 1'b0; err_o_seen = 1'b0; de_seen = 1'b0;

      // rst vs hs de rgb | de_o hs_o vs_o rgb_o x y ls fs mv wm hm fc ew eo
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 24'habcdef, 1'b0, 1'b0, 1'b0, 24'h000000, 11'd0, 11'd0,
                   1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000, 11'd0, 11'd0,
                   1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000, 11'd0, 11'd0,
                   1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h010203, 1'b1, 1'b0, 1'b0, 24'h010203, 11'd0, 11'd0,
                   1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h040506, 1'b1, 1'b0, 1'b0, 24'h040506, 11'd1, 11'd0,
                   1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h070809, 1'b1, 1'b0, 1'b0, 24'h070809, 11'd2, 11'd0,
                   1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 11'd2, 11'd0,
                   1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h0a0b0c, 1'b1, 1'b0, 1'b0, 24'h0a0b0c, 11'd0, 11'd1,
                   1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h0d0e0f, 1'b1, 1'b0, 1'b0, 24'h0d0e0f, 11'd1, 11'd1,
                   1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 11'd1, 11'd1,
                   1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000, 11'd1, 11'd1,
                   1'b0, 1'b0, 1'b1, 11'd3, 11'd2, 8'd1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 11'd1, 11'd1,
                   1'b0, 1'b0, 1'b0, 11'd3, 11'd2, 8'd1, 1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         rst   = vecs[i].rst;
         vs_in = vecs[i].vs;
         hs_in = vecs[i].hs;
         de_in = vecs[i].de;
         {r_in, g_in, b_in} = vecs[i].rgb;
         tick();
         check($sformatf("vec%0d_stream", i), 64'({de_out, hs_out, vs_out, r_out, g_out, b_out}),
               64'({vecs[i].de_o, vecs[i].hs_o, vecs[i].vs_o, vecs[i].rgb_o}));
         check($sformatf("vec%0d_xy", i), 64'({x_out, y_out, line_start, frame_start}),
               64'({vecs[i].x, vecs[i].y, vecs[i].ls, vecs[i].fs}));
         check($sformatf("vec%0d_meas", i),
               64'({meas_valid, width_meas, height_meas, frame_cnt, err_width, err_ovf}),
               64'({vecs[i].mv, vecs[i].wm, vecs[i].hm, vecs[i].fc, vecs[i].ew, vecs[i].eo}));
      end

      // Nominal 64x64 frames; the first vsync after reset closes nothing.
      pulse_reset();
      err_w_seen = 1'b0; err_o_seen = 1'b0;
      gen_frame(64, 64, -1, 0, -1, 1'b0);
      check("nominal_no_meas_first_vs", 64'(mv_seen), 64'd0);
      gen_frame(64, 64, -1, 0, -1, 1'b1);
      check("nominal_meas_count_2", 64'(mv_seen), 64'd1);
      check("nominal_meas_2", 64'({mv_w, mv_h, mv_fc, mv_ew, mv_eo}), 64'({11'd64, 11'd64, 8'd1, 1'b0, 1'b0}));
      gen_frame(64, 64, -1, 0, -1, 1'b0);
      check("nominal_meas_count_3", 64'(mv_seen), 64'd2);
      check("nominal_meas_3", 64'({mv_w, mv_h, mv_fc}), 64'({11'd64, 11'd64, 8'd2}));
      check("nominal_no_errors", 64'({err_w_seen, err_o_seen}), 64'd0);

      // Short line 10 raises err_width; it is still set at frame end.
      gen_frame(64, 64, 10, 63, -1, 1'b0);
      check("short_err_width_sticky", 64'(err_width), 64'd1);

      // Next frame closes the short-line frame, then reset hits at line 20.
      gen_frame(64, 64, -1, 0, 20, 1'b0);
      check("short_frame_meas", 64'({mv_w, mv_h, mv_fc, mv_ew}), 64'({11'd64, 11'd64, 8'd4, 1'b0}));
      check("reset_no_de_out", 64'(de_seen), 64'd0);
      check("reset_no_meas_rest", 64'(mv_seen), 64'd0);
      gen_frame(64, 64, -1, 0, -1, 1'b0);
      check("reset_no_meas_next_vs", 64'(mv_seen), 64'd0);
      check("reset_de_out_resumes", 64'(de_seen), 64'd1);
      gen_frame(64, 64, -1, 0, -1, 1'b0);
      check("reset_first_meas", 64'({mv_seen[7:0], mv_w, mv_h, mv_fc}), 64'({8'd1, 11'd64, 11'd64, 8'd1}));

      // Vsync and DE rising together.
      tiny_frame(3, 2, 1'b1);
      check("coincide_meas_prev", 64'({mv_w, mv_h, mv_fc}), 64'({11'd64, 11'd64, 8'd2}));
      tiny_frame(3, 2, 1'b1);
      check("coincide_meas_tiny", 64'({mv_w, mv_h, mv_fc}), 64'({11'd3, 11'd2, 8'd3}));

      // One 2100-cycle DE run saturates x.
      vs_in = 1'b1; de_in = 1'b0; tick();
      vs_in = 1'b0; tick();
      de_in = 1'b1;
      repeat (2100) tick();
      check("ovf_x_saturated", 64'({de_out, x_out, err_ovf}), 64'({1'b1, 11'd2047, 1'b1}));
      de_in = 1'b0; tick();
      vs_in = 1'b1; tick();
      check("ovf_cleared_on_close", 64'({meas_valid, err_ovf}), 64'({1'b1, 1'b0}));
      vs_in = 1'b0; tick();

      // 257 tiny frames after reset: 256 closes wrap frame_cnt to 0.
      pulse_reset();
      for (int k = 0; k <= 256; k++) begin
         tiny_frame(2, 2, 1'b0);
         if (k == 255) check("wrap_frame_cnt_255", 64'(frame_cnt), 64'd255);
      end
      check("wrap_frame_cnt_0", 64'(frame_cnt), 64'd0);
      check("wrap_meas_count", 64'(mv_seen), 64'd256);
      check("wrap_tiny_meas", 64'({mv_w, mv_h}), 64'({11'd2, 11'd2}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
